// File: rtl/control_desplazamiento_pkg.sv
// Shared codes for the universal shift register sequencer: cell modes, operations and FSM states.
package control_desplazamiento_pkg;

    localparam logic [1:0] MODO_HOLD  = 2'b00;
    localparam logic [1:0] MODO_SHIFT = 2'b01;
    localparam logic [1:0] MODO_LOAD  = 2'b10;
    localparam logic [1:0] MODO_ROT   = 2'b11;

    localparam logic [1:0] OP_TX  = 2'b00;
    localparam logic [1:0] OP_RX  = 2'b01;
    localparam logic [1:0] OP_ROT = 2'b10;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StLoad  = 2'b01,
        StShift = 2'b10,
        StDone  = 2'b11
    } estado_e;

    // Cell mode used on a non-stalled SHIFT cycle for the captured operation.
    function automatic logic [1:0] modo_desplazamiento(input logic [1:0] op_cap);
        return (op_cap == OP_ROT) ? MODO_ROT : MODO_SHIFT;
    endfunction

endpackage

// File: rtl/control_desplazamiento_contador_bits.sv
// Shift counter: clear has priority, increments on enable and saturates at N-1.
module control_desplazamiento_contador_bits #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_cuenta,
    output logic          o_tc
);

    logic [CW-1:0] r_cuenta;
    logic          w_tc;

    assign w_tc = (r_cuenta == CW'(N - 1));

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_cuenta <= '0;
        end else if (i_clr) begin
            r_cuenta <= '0;
        end else if (i_en && !w_tc) begin
            r_cuenta <= r_cuenta + 1'b1;
        end
    end

    assign o_cuenta = r_cuenta;
    assign o_tc     = w_tc;

endmodule

// File: rtl/control_desplazamiento.sv
// Sequencer for the universal shift register: transmit, receive and rotate with pause and abort.
module control_desplazamiento
    import control_desplazamiento_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic          pausa,
    input  logic          abortar,
    output logic [1:0]    modo,
    output logic [CW-1:0] cuenta,
    output logic          ocupado,
    output logic          listo
);

    estado_e    r_state;
    logic [1:0] r_op;

    logic w_accept;
    logic w_abort;
    logic w_avanza;
    logic w_tc;

    // Abort in IDLE is a no-op but still blocks a start on the same edge.
    assign w_accept = (r_state == StIdle) && start && !abortar &&
                      ((op == OP_TX) || (op == OP_RX) || (op == OP_ROT));
    assign w_abort  = abortar && (r_state != StIdle);
    assign w_avanza = (r_state == StShift) && !pausa && !abortar;

    control_desplazamiento_contador_bits #(
        .N  (N),
        .CW (CW)
    ) u_contador (
        .clk      (clk),
        .reset_L  (reset_L),
        .i_clr    (w_accept || w_abort),
        .i_en     (w_avanza),
        .o_cuenta (cuenta),
        .o_tc     (w_tc)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= StIdle;
            r_op    <= OP_TX;
        end else if (w_abort) begin
            r_state <= StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_op    <= op;
                        r_state <= (op == OP_TX) ? StLoad : StShift;
                    end
                end
                StLoad:  r_state <= StShift;
                StShift: begin
                    if (!pausa && w_tc) begin
                        r_state <= StDone;
                    end
                end
                StDone:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        modo = MODO_HOLD;
        unique case (r_state)
            StLoad:  modo = MODO_LOAD;
            StShift: modo = pausa ? MODO_HOLD : modo_desplazamiento(r_op);
            default: modo = MODO_HOLD;
        endcase
    end

    assign ocupado = (r_state != StIdle);
    assign listo   = (r_state == StDone);

endmodule

// File: tb/tb_control_desplazamiento.sv
// Directed and random stimulus for control_desplazamiento against an operation-level model.
module tb_control_desplazamiento;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset_L;
    logic          start;
    logic [1:0]    op;
    logic          pausa;
    logic          abortar;
    logic [1:0]    modo;
    logic [CW-1:0] cuenta;
    logic          ocupado;
    logic          listo;

    int checks = 0;
    int errors = 0;

    // Model: an operation is busy, may owe a load cycle, has shifts left, may be in its done cycle.
    bit m_busy;
    bit m_load;
    bit m_done;
    int m_left;
    int m_cnt;
    int m_op;

    logic [1:0] tx_seq [6];

    control_desplazamiento #(
        .N  (N),
        .CW (CW)
    ) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .start   (start),
        .op      (op),
        .pausa   (pausa),
        .abortar (abortar),
        .modo    (modo),
        .cuenta  (cuenta),
        .ocupado (ocupado),
        .listo   (listo)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_busy = 1'b0;
        m_load = 1'b0;
        m_done = 1'b0;
        m_left = 0;
        m_cnt  = 0;
        m_op   = 0;
    endtask

    task automatic model_edge();
        if (m_busy && abortar) begin
            m_busy = 1'b0;
            m_load = 1'b0;
            m_done = 1'b0;
            m_cnt  = 0;
        end else if (!m_busy) begin
            if (start && op != 2'd3 && !abortar) begin
                m_busy = 1'b1;
                m_op   = int'(op);
                m_cnt  = 0;
                m_load = (op == 2'd0);
                m_left = N;
                m_done = 1'b0;
            end
        end else if (m_load) begin
            m_load = 1'b0;
        end else if (m_done) begin
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (!pausa) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
            else             m_cnt++;
        end
    endtask

    task automatic compare(input string tag);
        logic [1:0] e_modo;
        logic       e_listo;
        e_modo  = 2'd0;
        e_listo = 1'b0;
        if (m_busy) begin
            if (m_load)      e_modo = 2'd2;
            else if (m_done) e_listo = 1'b1;
            else if (!pausa) e_modo = (m_op == 2) ? 2'd3 : 2'd1;
        end
        checks++;
        assert (modo === e_modo) else begin
            errors++;
            $error("FAIL %s modo got %0d expected %0d", tag, modo, e_modo);
        end
        checks++;
        assert (cuenta === CW'(m_cnt)) else begin
            errors++;
            $error("FAIL %s cuenta got %0d expected %0d", tag, cuenta, m_cnt);
        end
        checks++;
        assert (ocupado === m_busy) else begin
            errors++;
            $error("FAIL %s ocupado got %0d expected %0d", tag, ocupado, m_busy);
        end
        checks++;
        assert (listo === e_listo) else begin
            errors++;
            $error("FAIL %s listo got %0d expected %0d", tag, listo, e_listo);
        end
    endtask

    task automatic step(input logic s, input logic [1:0] o, input logic p, input logic a,
                        input logic r, input string tag);
        start   = s;
        op      = o;
        pausa   = p;
        abortar = a;
        reset_L = r;
        #1;
        if (!r) model_reset();
        compare(tag);
        @(posedge clk);
        if (r) model_edge();
        #1;
    endtask

    task automatic expect_val(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        tx_seq = '{2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
        model_reset();
        start   = 1'b0;
        op      = 2'd0;
        pausa   = 1'b0;
        abortar = 1'b0;
        reset_L = 1'b0;

        step(0, 0, 0, 0, 0, "reset");
        step(0, 0, 0, 0, 0, "reset_hold");
        step(0, 0, 0, 0, 1, "idle");

        // Transmit: fixed mode sequence after the accepting edge.
        step(1, 0, 0, 0, 1, "tx_start");
        for (int i = 0; i < 6; i++) begin
            start = 1'b0;
            #1;
            expect_val("tx_modo_seq", int'(modo), int'(tx_seq[i]));
            step(0, 0, 0, 0, 1, "tx_run");
        end
        step(0, 0, 0, 0, 1, "tx_idle");

        // Receive with a two-cycle pause after the second shift.
        step(1, 1, 0, 0, 1, "rx_start");
        step(0, 1, 0, 0, 1, "rx_shift");
        step(0, 1, 0, 0, 1, "rx_shift");
        step(0, 1, 1, 0, 1, "rx_pause");
        expect_val("rx_cuenta_frozen", int'(cuenta), 2);
        step(0, 1, 1, 0, 1, "rx_pause");
        expect_val("rx_cuenta_frozen2", int'(cuenta), 2);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1, "rx_run");

        // Rotate.
        step(1, 2, 0, 0, 1, "rot_start");
        for (int i = 0; i < 6; i++) step(0, 2, 0, 0, 1, "rot_run");

        // Abort on the third SHIFT cycle of a transmit.
        step(1, 0, 0, 0, 1, "ab_start");
        step(0, 0, 0, 0, 1, "ab_load");
        step(0, 0, 0, 0, 1, "ab_shift");
        step(0, 0, 0, 0, 1, "ab_shift");
        step(0, 0, 1, 1, 1, "ab_abort");
        expect_val("ab_ocupado", int'(ocupado), 0);
        expect_val("ab_cuenta", int'(cuenta), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, "ab_after");

        // Reserved op and abort-in-idle both leave the sequencer idle.
        step(1, 3, 0, 0, 1, "op11");
        expect_val("op11_ocupado", int'(ocupado), 0);
        step(1, 1, 0, 1, 1, "idle_abort_start");
        expect_val("idle_abort_ocupado", int'(ocupado), 0);
        step(0, 0, 0, 0, 1, "idle");

        // start held high: back-to-back transmits.
        for (int i = 0; i < 2 * (N + 3) + 2; i++) step(1, 0, 0, 0, 1, "b2b");
        step(0, 0, 0, 0, 1, "b2b_tail");
        for (int i = 0; i < N + 3; i++) step(0, 0, 0, 0, 1, "b2b_drain");

        // Asynchronous reset in the middle of a shift.
        step(1, 0, 0, 0, 1, "rst_start");
        step(0, 0, 0, 0, 1, "rst_load");
        step(0, 0, 0, 0, 1, "rst_shift");
        step(0, 0, 0, 0, 0, "rst_mid");
        expect_val("rst_mid_ocupado", int'(ocupado), 0);
        step(0, 0, 0, 0, 1, "rst_release");

        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 63) != 0), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
